// File: rtl/micromotion_pkg.sv
// Shared types and default widths for the micromotion stimulus generator.
package micromotion_pkg;

  localparam int unsigned DefDataSize  = 8;
  localparam int unsigned DefCountSize = 32;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

endpackage

// File: rtl/micromotion_stim_gen.sv
// Square-wave reference (c_ch2) plus phase-delayed synthetic photon pulse (c_ch1),
// with pulse counting, graceful stop and quota-based completion.
module micromotion_stim_gen
  import micromotion_pkg::*;
#(
  parameter int unsigned DATASIZE  = DefDataSize,
  parameter int unsigned COUNTSIZE = DefCountSize,
  parameter int unsigned PULSE_W   = 2
) (
  input  logic                 c_clk,
  input  logic                 c_rst,
  input  logic                 c_start,
  input  logic                 c_stop,
  input  logic [DATASIZE-1:0]  c_period,
  input  logic [DATASIZE-1:0]  c_high,
  input  logic [DATASIZE-1:0]  c_phase,
  input  logic [COUNTSIZE-1:0] c_num_pulses,
  output logic                 c_ch2,
  output logic                 c_ch1,
  output logic                 c_busy,
  output logic                 c_done,
  output logic                 c_err,
  output logic [COUNTSIZE-1:0] c_pulse_count
);

  state_e               state_q, state_d;
  logic [DATASIZE-1:0]  period_q, period_d, high_q, high_d, phase_q, phase_d, p_q, p_d;
  logic [COUNTSIZE-1:0] num_q, num_d, count_q, count_d;
  logic                 stop_q, stop_d, ch1_q, ch1_d, ch2_q, ch2_d;
  logic                 done_q, done_d, err_q, err_d;
  logic                 run_d, allow, wrap, halt, cfg_ok, win;
  logic [DATASIZE:0]    win_end;

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    high_d   = high_q;
    phase_d  = phase_q;
    num_d    = num_q;
    p_d      = p_q;
    count_d  = count_q;
    stop_d   = stop_q;
    ch1_d    = 1'b0;
    ch2_d    = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    run_d    = 1'b0;
    allow    = 1'b1;

    cfg_ok = (c_period >= DATASIZE'(2)) && (c_high != '0) && (c_high < c_period);
    wrap   = (p_q == period_q - DATASIZE'(1));
    halt   = stop_q | c_stop | ((num_q != '0) && (count_q == num_q));

    unique case (state_q)
      StIdle: begin
        if (c_start) begin
          if (cfg_ok) begin
            period_d = c_period;
            high_d   = c_high;
            phase_d  = c_phase;
            num_d    = c_num_pulses;
            p_d      = '0;
            count_d  = '0;
            stop_d   = 1'b0;  // a stop arriving with the start is discarded
            state_d  = StRun;
            run_d    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (wrap && halt) begin
          state_d = StIdle;
          done_d  = 1'b1;
          stop_d  = 1'b0;
          p_d     = '0;
        end else begin
          run_d  = 1'b1;
          p_d    = wrap ? '0 : p_q + DATASIZE'(1);
          stop_d = stop_q | c_stop;
          allow  = ~halt;
        end
      end
      default: state_d = StIdle;
    endcase

    // Window end is one bit wider so phase+PULSE_W never wraps.
    win_end = {1'b0, phase_d} + (DATASIZE+1)'(PULSE_W);
    win     = (phase_d < period_d) && (p_d >= phase_d) && ({1'b0, p_d} < win_end);

    if (run_d) begin
      ch2_d = (p_d < high_d);
      // A pulse may only begin at p==phase; later window cycles just continue it.
      ch1_d = win && ((p_d == phase_d) ? allow : ch1_q);
      if (ch1_d && !ch1_q && (count_d != '1)) begin
        count_d = count_d + COUNTSIZE'(1);
      end
    end
  end

  always_ff @(posedge c_clk or posedge c_rst) begin
    if (c_rst) begin
      state_q  <= StIdle;
      period_q <= '0;
      high_q   <= '0;
      phase_q  <= '0;
      num_q    <= '0;
      p_q      <= '0;
      count_q  <= '0;
      stop_q   <= 1'b0;
      ch1_q    <= 1'b0;
      ch2_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      high_q   <= high_d;
      phase_q  <= phase_d;
      num_q    <= num_d;
      p_q      <= p_d;
      count_q  <= count_d;
      stop_q   <= stop_d;
      ch1_q    <= ch1_d;
      ch2_q    <= ch2_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign c_ch1         = ch1_q;
  assign c_ch2         = ch2_q;
  assign c_busy        = (state_q == StRun);
  assign c_done        = done_q;
  assign c_err         = err_q;
  assign c_pulse_count = count_q;

endmodule

// File: tb/tb_micromotion_stim_gen.sv
// Scoreboard bench: expected per-cycle outputs are queued when a run is launched
// and popped one per clock after each rising edge.
module tb_micromotion_stim_gen;

  localparam int PW = 2;

  logic        c_clk = 1'b0;
  logic        c_rst;
  logic        c_start, c_stop;
  logic [7:0]  c_period, c_high, c_phase;
  logic [31:0] c_num_pulses;
  logic        c_ch2, c_ch1, c_busy, c_done, c_err;
  logic [31:0] c_pulse_count;

  micromotion_stim_gen #(
    .DATASIZE (8),
    .COUNTSIZE(32),
    .PULSE_W  (PW)
  ) dut (
    .c_clk        (c_clk),
    .c_rst        (c_rst),
    .c_start      (c_start),
    .c_stop       (c_stop),
    .c_period     (c_period),
    .c_high       (c_high),
    .c_phase      (c_phase),
    .c_num_pulses (c_num_pulses),
    .c_ch2        (c_ch2),
    .c_ch1        (c_ch1),
    .c_busy       (c_busy),
    .c_done       (c_done),
    .c_err        (c_err),
    .c_pulse_count(c_pulse_count)
  );

  always #5 c_clk = ~c_clk;

  typedef struct packed {
    logic        ch2;
    logic        ch1;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int unsigned last_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic push_idle(input bit done, input bit err);
    exp_t e;
    e = '{ch2: 1'b0, ch1: 1'b0, busy: 1'b0, done: done, err: err, cnt: last_cnt};
    sb.push_back(e);
  endtask

  // Expected run: p = k mod per; ch2 = p<hi; a pulse starts at p==ph unless stopped
  // (stop seen at end of cycle stop_k) or the quota is met, and lasts PW clocks
  // clipped at the period end.
  task automatic push_run(input int per, input int hi, input int ph, input int num,
                          input int nrun, input int stop_k, input bit with_done);
    exp_t        e;
    int unsigned cnt;
    bit          started;
    int          p;
    cnt     = 0;
    started = 0;
    for (int k = 0; k < nrun; k++) begin
      p = k % per;
      if (p == 0) started = 0;
      if (p == ph && ph < per) begin
        started = !(stop_k >= 0 && k > stop_k) && !(num != 0 && cnt == num);
        if (started) cnt++;
      end
      e.ch2  = (p < hi);
      e.ch1  = started && (ph < per) && (p >= ph) && (p < ph + PW);
      e.busy = 1'b1;
      e.done = 1'b0;
      e.err  = 1'b0;
      e.cnt  = cnt;
      sb.push_back(e);
    end
    last_cnt = cnt;
    if (with_done) push_idle(1'b1, 1'b0);
  endtask

  task automatic cycle();
    exp_t e;
    @(posedge c_clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("ch2", c_ch2, e.ch2);
      check("ch1", c_ch1, e.ch1);
      check("busy", c_busy, e.busy);
      check("done", c_done, e.done);
      check("err", c_err, e.err);
      check("pulse_count", c_pulse_count, e.cnt);
    end
  endtask

  task automatic set_cfg(input int per, input int hi, input int ph, input int num);
    c_period     = 8'(per);
    c_high       = 8'(hi);
    c_phase      = 8'(ph);
    c_num_pulses = 32'(num);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    c_rst   = 1'b1;
    c_start = 1'b0;
    c_stop  = 1'b0;
    set_cfg(0, 0, 0, 0);
    repeat (3) @(posedge c_clk);
    #1;
    check("rst_ch1", c_ch1, 1'b0);
    check("rst_ch2", c_ch2, 1'b0);
    check("rst_busy", c_busy, 1'b0);
    check("rst_done", c_done, 1'b0);
    check("rst_err", c_err, 1'b0);
    check("rst_count", c_pulse_count, 32'd0);
    c_rst = 1'b0;
    @(negedge c_clk);

    // period 10, high 5, phase 3, 4 pulses
    set_cfg(10, 5, 3, 4);
    c_start = 1'b1;
    push_run(10, 5, 3, 4, 40, -1, 1'b1);
    cycle();
    c_start = 1'b0;
    repeat (40) cycle();
    push_idle(1'b0, 1'b0);
    cycle();
    check("s1_final_count", c_pulse_count, 32'd4);

    // phase at the last period slot: pulse clipped to p7 only
    set_cfg(8, 4, 7, 2);
    c_start = 1'b1;
    push_run(8, 4, 7, 2, 16, -1, 1'b1);
    cycle();
    c_start = 1'b0;
    repeat (16) cycle();

    // rejected configurations
    for (int i = 0; i < 3; i++) begin
      if (i == 0) set_cfg(1, 0, 0, 1);
      else if (i == 1) set_cfg(10, 0, 0, 1);
      else set_cfg(10, 10, 0, 1);
      c_start = 1'b1;
      push_idle(1'b0, 1'b1);
      cycle();
      c_start = 1'b0;
      push_idle(1'b0, 1'b0);
      cycle();
    end

    // continuous run stopped at k=13; config changes mid-run are ignored
    set_cfg(10, 5, 5, 0);
    c_start = 1'b1;
    push_run(10, 5, 5, 0, 20, 13, 1'b1);
    cycle();
    c_start = 1'b0;
    set_cfg(3, 1, 0, 1);
    for (int k = 1; k <= 20; k++) begin
      c_stop = (k - 1 == 13);
      cycle();
    end
    c_stop = 1'b0;

    // phase beyond period, start with simultaneous stop (stop discarded)
    set_cfg(10, 5, 12, 0);
    c_start = 1'b1;
    c_stop  = 1'b1;
    push_run(10, 5, 12, 0, 20, 14, 1'b1);
    cycle();
    c_start = 1'b0;
    c_stop  = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      c_stop = (k - 1 == 14);
      cycle();
    end
    c_stop = 1'b0;

    // start held high across completion restarts after a single idle cycle
    set_cfg(4, 2, 1, 1);
    c_start = 1'b1;
    push_run(4, 2, 1, 1, 4, -1, 1'b1);
    push_run(4, 2, 1, 1, 4, -1, 1'b1);
    repeat (5) cycle();
    cycle();
    c_start = 1'b0;
    repeat (4) cycle();

    // asynchronous reset in the middle of a pulse
    set_cfg(10, 5, 4, 0);
    c_start = 1'b1;
    push_run(10, 5, 4, 0, 6, -1, 1'b0);
    cycle();
    c_start = 1'b0;
    repeat (5) cycle();
    #2 c_rst = 1'b1;
    #1;
    check("arst_ch1", c_ch1, 1'b0);
    check("arst_ch2", c_ch2, 1'b0);
    check("arst_busy", c_busy, 1'b0);
    check("arst_count", c_pulse_count, 32'd0);
    #2 c_rst = 1'b0;
    last_cnt = 0;

    // first start right after reset release, phase 0
    set_cfg(2, 1, 0, 1);
    c_start = 1'b1;
    push_run(2, 1, 0, 1, 2, -1, 1'b1);
    cycle();
    c_start = 1'b0;
    repeat (2) cycle();

    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
